// File: rtl/change_dispenser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispenser_pkg: denominations, coin values, payout FSM states      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package change_dispenser_pkg;

  localparam int NUM_DEN = 5;

  localparam logic [2:0] DEN_NICKEL  = 3'd0;
  localparam logic [2:0] DEN_DIME    = 3'd1;
  localparam logic [2:0] DEN_QUARTER = 3'd2;
  localparam logic [2:0] DEN_FIFTY   = 3'd3;
  localparam logic [2:0] DEN_DOLLAR  = 3'd4;

  localparam logic [7:0] MAX_AMOUNT = 8'd200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT_SENSE,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Coin value in nickels.
  function automatic logic [7:0] den_value(input logic [2:0] idx);
    case (idx)
      DEN_DOLLAR:  den_value = 8'd20;
      DEN_FIFTY:   den_value = 8'd10;
      DEN_QUARTER: den_value = 8'd5;
      DEN_DIME:    den_value = 8'd2;
      DEN_NICKEL:  den_value = 8'd1;
      default:     den_value = 8'd0;
    endcase
  endfunction

  // Greedy choice: later (higher-value) hits overwrite earlier ones.
  function automatic pick_t pick_den(input logic [7:0] rem, input logic [4:0] avail);
    pick_t p;
    p = '0;
    for (int i = 0; i < NUM_DEN; i++) begin
      if (avail[i] && (den_value(3'(i)) <= rem)) begin
        p.found = 1'b1;
        p.idx   = 3'(i);
      end
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispenser_sync: 2-flop sync + falling-edge pulse on coin sensor   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module change_dispenser_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_seen_n_i,
  output logic coin_edge_o
);

  logic sync1_q, sync2_q, prev_q, edge_q;

  // Sensor idles high, so the chain resets high to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= coin_seen_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= prev_q & ~sync2_q;
    end
  end

  assign coin_edge_o = edge_q;

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispenser: greedy coin-hopper payout with sensor confirm/timeout  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 5_000_000,
  parameter int unsigned GAP_CYCLES     = 2_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] amount_i,
  input  logic [4:0] empty_n_i,
  input  logic       coin_seen_n_i,
  output logic [4:0] eject_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fault_o,
  output logic [7:0] remaining_o,
  output logic [7:0] coins_out_o
);

  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       coins_q, coins_d;
  logic             coin_edge;
  pick_t            pick;

  change_dispenser_sync u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_seen_n_i(coin_seen_n_i),
    .coin_edge_o  (coin_edge)
  );

  assign pick = pick_den(rem_q, empty_n_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      den_q   <= DEN_NICKEL;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rem_q   <= '0;
      coins_q <= '0;
    end else begin
      state_q <= state_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rem_q   <= rem_d;
      coins_q <= coins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rem_d   = rem_q;
    coins_d = coins_q;
    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (start_i) begin
          rem_d   = (amount_i > MAX_AMOUNT) ? MAX_AMOUNT : amount_i;
          coins_d = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (pick.found) begin
          den_d   = pick.idx;
          cnt_d   = PULSE_LOAD;
          tmo_d   = '0;
          state_d = ST_EJECT;
        end else begin
          state_d = ST_FAULT;
        end
      end
      // A confirmed coin outranks a timeout landing on the same cycle.
      ST_EJECT, ST_WAIT_SENSE: begin
        tmo_d = tmo_q + 1'b1;
        if (coin_edge) begin
          rem_d   = rem_q - den_value(den_q);
          coins_d = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAULT;
        end else if (state_q == ST_EJECT) begin
          if (cnt_q == '0) state_d = ST_WAIT_SENSE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_SELECT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign eject_o     = (state_q == ST_EJECT) ? (5'b00001 << den_q) : 5'b00000;
  assign busy_o      = (state_q == ST_SELECT) || (state_q == ST_EJECT) ||
                       (state_q == ST_WAIT_SENSE) || (state_q == ST_GAP);
  assign done_o      = (state_q == ST_DONE);
  assign fault_o     = (state_q == ST_FAULT);
  assign remaining_o = rem_q;
  assign coins_out_o = coins_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_change_dispenser: timeline reference model + per-cycle compare        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_change_dispenser;

  localparam int K_DONE    = 0;
  localparam int K_NODEN   = 1;
  localparam int K_TIMEOUT = 2;
  localparam int PER_COIN  = 9;   // 4 eject + 2 wait + 2 gap + 1 select
  localparam int TMO       = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] amount_i = 8'd0;
  logic [4:0] empty_n_i = 5'b11111;
  logic       coin_seen_n_i = 1'b1;
  logic [4:0] eject_o;
  logic       busy_o, done_o, fault_o;
  logic [7:0] remaining_o, coins_out_o;

  change_dispenser #(
    .PULSE_CYCLES  (4),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .amount_i     (amount_i),
    .empty_n_i    (empty_n_i),
    .coin_seen_n_i(coin_seen_n_i),
    .eject_o      (eject_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fault_o      (fault_o),
    .remaining_o  (remaining_o),
    .coins_out_o  (coins_out_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  bit   m_mode = 1'b0;   // 0: fresh from reset, everything zero
  int   m_N, m_amt, m_n, m_kind, m_tend, m_pend;
  int   m_den [0:255];
  int   m_rem [0:256];

  function automatic int val(input int i);
    case (i)
      4: return 20;
      3: return 10;
      2: return 5;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic model_setup(input int amt, input logic [4:0] mask, input bit sen);
    int rem, best;
    rem = (amt > 200) ? 200 : amt;
    m_amt = rem; m_n = 0; m_rem[0] = rem; m_pend = 0;
    forever begin
      if (rem == 0) begin m_kind = K_DONE; break; end
      best = -1;
      for (int i = 4; i >= 0; i--) begin
        if (mask[i] && val(i) <= rem) begin best = i; break; end
      end
      if (best < 0) begin m_kind = K_NODEN; break; end
      if (!sen) begin m_kind = K_TIMEOUT; m_pend = best; break; end
      m_den[m_n] = best;
      rem = rem - val(best);
      m_n++;
      m_rem[m_n] = rem;
    end
    m_tend = 2 + PER_COIN * m_n;
  endtask

  task automatic model_at(input int t, output logic [4:0] e, output logic b, output logic d,
                          output logic f, output logic [7:0] r, output logic [7:0] c);
    int k, j;
    e = 5'd0; b = 1'b0; d = 1'b0; f = 1'b0; r = 8'd0; c = 8'd0;
    if (m_mode == 1'b0) return;
    if (t < m_tend) begin
      b = 1'b1;
      if (t == 1) begin
        r = 8'(m_amt);
      end else begin
        k = (t - 2) / PER_COIN;
        j = (t - 2) % PER_COIN;
        if (j < 4) e = 5'(1 << m_den[k]);
        if (j >= 6) begin r = 8'(m_rem[k+1]); c = 8'(k + 1); end
        else        begin r = 8'(m_rem[k]);   c = 8'(k);     end
      end
    end else begin
      r = 8'(m_rem[m_n]);
      c = 8'((m_n > 255) ? 255 : m_n);
      case (m_kind)
        K_DONE:  d = (t == m_tend);
        K_NODEN: f = 1'b1;
        default: begin
          if (t < m_tend + TMO) begin
            b = 1'b1;
            if (t - m_tend < 4) e = 5'(1 << m_pend);
          end else begin
            f = 1'b1;
          end
        end
      endcase
    end
  endtask

  // ---------------- compare process + monitors ----------------
  logic [4:0] x_e;
  logic       x_b, x_d, x_f;
  logic [7:0] x_r, x_c;
  int         t_now;
  logic [4:0] ej_seq[$];
  logic [7:0] rise_rem[$];
  int         ej_cycles, done_cnt, done_t, fault_t;
  logic [4:0] prev_ej_mon = 5'd0;
  logic       prev_f_mon = 1'b0;

  always @(negedge clk) begin
    t_now = cyc - m_N;
    if (m_mode == 1'b0 || t_now >= 1) begin
      model_at(t_now, x_e, x_b, x_d, x_f, x_r, x_c);
      chk("eject",     32'(eject_o),     32'(x_e));
      chk("busy",      32'(busy_o),      32'(x_b));
      chk("done",      32'(done_o),      32'(x_d));
      chk("fault",     32'(fault_o),     32'(x_f));
      chk("remaining", 32'(remaining_o), 32'(x_r));
      chk("coins_out", 32'(coins_out_o), 32'(x_c));
    end
    if (m_mode == 1'b1) begin
      if (eject_o != 5'd0 && prev_ej_mon == 5'd0) begin
        ej_seq.push_back(eject_o);
        rise_rem.push_back(remaining_o);
      end
      if (eject_o != 5'd0) ej_cycles++;
      if (done_o) begin done_cnt++; done_t = t_now; end
      if (fault_o && !prev_f_mon) fault_t = t_now;
    end
    prev_ej_mon = eject_o;
    prev_f_mon  = fault_o;
  end

  // ---------------- hopper sensor model ----------------
  bit         sensor_en = 1'b1;
  int         low_at = -1, high_at = -1;
  logic [4:0] prev_ej_sen = 5'd0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (eject_o != 5'd0 && prev_ej_sen == 5'd0) begin
        low_at  = cyc + 2;
        high_at = cyc + 5;
      end
      prev_ej_sen = eject_o;
      if (sensor_en && cyc == low_at) coin_seen_n_i = 1'b0;
      if (cyc == high_at) coin_seen_n_i = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic begin_req(input int amt, input logic [4:0] mask, input bit sen);
    @(posedge clk); #1;
    empty_n_i = mask;
    sensor_en = sen;
    model_setup(amt, mask, sen);
    ej_seq.delete(); rise_rem.delete();
    ej_cycles = 0; done_cnt = 0; done_t = -1; fault_t = -1;
    m_N = cyc; m_mode = 1'b1;
    start_i = 1'b1;
    amount_i = 8'(amt);
  endtask

  task automatic run_req(input int amt, input logic [4:0] mask, input bit sen, input bit noise);
    int busy_end, nt;
    begin_req(amt, mask, sen);
    busy_end = (m_kind == K_TIMEOUT) ? m_tend + TMO : m_tend;
    nt = noise ? int'($urandom_range(busy_end - 1, 1)) : -1;
    for (int t = 1; t <= busy_end + 4; t++) begin
      @(posedge clk); #1;
      start_i  = (t == nt);
      amount_i = 8'($urandom);
    end
    start_i = 1'b0;
  endtask

  logic [4:0] exp_seq1 [4];
  logic [7:0] exp_rem1 [4];
  logic [4:0] exp_seq2 [3];

  initial begin
    exp_seq1 = '{5'b10000, 5'b01000, 5'b00100, 5'b00010};
    exp_rem1 = '{8'd37, 8'd17, 8'd7, 8'd2};
    exp_seq2 = '{5'b00010, 5'b00010, 5'b00001};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_remaining", 32'(remaining_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 37 nickels, all hoppers full, with a stray start mid-payout
    run_req(37, 5'b11111, 1'b1, 1'b1);
    chk("t1_coin_count", 32'(ej_seq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_eject_seq", (i < ej_seq.size()) ? 32'(ej_seq[i]) : 32'hFFFF, 32'(exp_seq1[i]));
      chk("t1_rem_at_eject", (i < rise_rem.size()) ? 32'(rise_rem[i]) : 32'hFFFF, 32'(exp_rem1[i]));
    end
    chk("t1_coins_out", 32'(coins_out_o), 32'd4);
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);
    chk("t1_done_time", 32'(done_t), 32'd38);

    // quarter hopper empty
    run_req(5, 5'b11011, 1'b1, 1'b0);
    chk("t2_coin_count", 32'(ej_seq.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t2_eject_seq", (i < ej_seq.size()) ? 32'(ej_seq[i]) : 32'hFFFF, 32'(exp_seq2[i]));
    chk("t2_coins_out", 32'(coins_out_o), 32'd3);
    chk("t2_done_pulses", 32'(done_cnt), 32'd1);

    // no payable coin, then restart from FAULT with amount 0
    run_req(3, 5'b11100, 1'b1, 1'b0);
    chk("t3_fault_time", 32'(fault_t), 32'd2);
    chk("t3_fault", 32'(fault_o), 32'd1);
    chk("t3_remaining", 32'(remaining_o), 32'd3);
    chk("t3_no_eject", 32'(ej_seq.size()), 32'd0);
    run_req(0, 5'b11111, 1'b1, 1'b0);
    chk("t3b_done_time", 32'(done_t), 32'd2);
    chk("t3b_fault", 32'(fault_o), 32'd0);

    // sensor dead -> timeout
    run_req(20, 5'b11111, 1'b0, 1'b0);
    chk("t4_eject_seq", (ej_seq.size() > 0) ? 32'(ej_seq[0]) : 32'hFFFF, 32'h10);
    chk("t4_eject_cycles", 32'(ej_cycles), 32'd4);
    chk("t4_fault_time", 32'(fault_t), 32'd18);
    chk("t4_remaining", 32'(remaining_o), 32'd20);
    chk("t4_coins_out", 32'(coins_out_o), 32'd0);

    // async reset during the first eject
    begin_req(30, 5'b11111, 1'b1);
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_eject_before_reset", 32'(eject_o), 32'h10);
    #1;
    rst_n  = 1'b0;
    m_mode = 1'b0;
    #1;
    chk("t5_eject_in_reset", 32'(eject_o), 32'd0);
    chk("t5_busy_in_reset", 32'(busy_o), 32'd0);
    chk("t5_remaining_in_reset", 32'(remaining_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t5_coins_after", 32'(coins_out_o), 32'd0);
    chk("t5_remaining_after", 32'(remaining_o), 32'd0);

    // zero amount
    run_req(0, 5'b11111, 1'b1, 1'b0);
    chk("t6_done_time", 32'(done_t), 32'd2);
    chk("t6_no_eject", 32'(ej_seq.size()), 32'd0);

    // clamp above 200
    run_req(250, 5'b11111, 1'b1, 1'b0);
    chk("t7_clamped", (rise_rem.size() > 0) ? 32'(rise_rem[0]) : 32'hFFFF, 32'd200);
    chk("t7_coins_out", 32'(coins_out_o), 32'd10);
    chk("t7_done_time", 32'(done_t), 32'd92);

    // randomized requests
    repeat (15) begin
      run_req(int'($urandom_range(0, 255)), 5'($urandom),
              ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, actual not finished required finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
